// File: rtl/mux_rr_nx1_pkg.sv
// mux_rr_nx1_pkg: shared mode encodings and width helper for the round-robin selector
package mux_rr_nx1_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: round-robin arbiter with an owned rotating priority pointer
module rr_arbiter_n
    import mux_rr_nx1_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2_min1(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                any_grant
);

    logic [SEL_W-1:0] ptr;

    // search from ptr upward with wrap; lowest offset from ptr wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % CHANNELS]) begin
                grant     = CHANNELS'(1) << ((int'(ptr) + i) % CHANNELS);
                grant_idx = SEL_W'((int'(ptr) + i) % CHANNELS);
                any_grant = 1'b1;
            end
        end
    end

    // pointer moves just past the channel that transferred
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance && any_grant)
            ptr <= (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N-channel fixed/round-robin selector with registered valid/ready output
module mux_rr_nx1
    import mux_rr_nx1_pkg::*;
#(
    parameter  int BITS     = 12,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2_min1(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS*BITS-1:0] in_data,
    input  logic [CHANNELS-1:0]      in_valid,
    output logic [CHANNELS-1:0]      in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [BITS-1:0]          out_data,
    output logic [SEL_W-1:0]         out_chan,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic                load;
    logic [CHANNELS-1:0] fix_hot;
    logic [CHANNELS-1:0] rr_grant;
    logic [SEL_W-1:0]    rr_idx;
    logic                rr_any;
    logic                gnt_any;
    logic [SEL_W-1:0]    gnt_idx;
    logic [BITS-1:0]     word;

    rr_arbiter_n #(.CHANNELS(CHANNELS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (load && !rst && mode == MODE_RR),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any_grant (rr_any)
    );

    // fixed-mode decode; out-of-range sel matches no channel
    always_comb begin
        fix_hot = '0;
        for (int k = 0; k < CHANNELS; k++)
            fix_hot[k] = (int'(sel) == k) && in_valid[k];
    end

    // mode mux, ready gating and winner word selection
    always_comb begin
        load     = !out_valid || out_ready;
        gnt_any  = (mode == MODE_RR) ? rr_any : |fix_hot;
        gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
        in_ready = (load && !rst) ? ((mode == MODE_RR) ? rr_grant : fix_hot) : '0;
        word     = gnt_any ? in_data[gnt_idx*BITS +: BITS] : '0;
    end

    // one-deep output register, reloads whenever the slot is empty or being drained
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            out_valid <= gnt_any;
            out_data  <= word;
            out_chan  <= gnt_any ? gnt_idx : '0;
        end
    end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// tb_mux_rr_nx1: randomized and directed checks against a behavioural selector model
module tb_mux_rr_nx1;

    logic        clk = 1'b0;
    logic        rst, mode, out_ready, out_valid;
    logic [1:0]  sel, out_chan;
    logic [3:0]  in_valid, in_ready;
    logic [47:0] in_data;
    logic [11:0] out_data;

    logic        rst3, mode3, out_ready3, out_valid3;
    logic [1:0]  sel3, out_chan3;
    logic [2:0]  in_valid3, in_ready3;
    logic [23:0] in_data3;
    logic [7:0]  out_data3;

    int vectors = 0;
    int miscompares = 0;

    int          m_ptr = 0;
    logic        m_valid = 1'b0;
    logic [11:0] m_data = '0;
    int          m_chan = 0;

    always #5 clk = ~clk;

    mux_rr_nx1 #(.BITS(12), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_rr_nx1 #(.BITS(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock of the 4-channel DUT: drive, check ready, advance model, check outputs
    task automatic step(input logic r, input logic m, input logic [1:0] s,
                        input logic [3:0] v, input logic ordy, input logic [47:0] d);
        logic       ld;
        int         g;
        logic [3:0] exp_rdy;
        rst = r; mode = m; sel = s; in_valid = v; out_ready = ordy; in_data = d;
        #1;
        ld = !m_valid || ordy;
        g = -1;
        if (m) begin
            for (int o = 0; o < 4; o++) begin
                if (v[(m_ptr + o) % 4]) begin
                    g = (m_ptr + o) % 4;
                    break;
                end
            end
        end else if (v[s]) begin
            g = int'(s);
        end
        exp_rdy = (!r && ld && g >= 0) ? 4'(1 << g) : 4'b0;
        check("in_ready", {60'b0, in_ready}, {60'b0, exp_rdy});
        if (r) begin
            m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
        end else if (ld) begin
            m_valid = (g >= 0);
            m_data  = (g >= 0) ? d[g*12 +: 12] : 12'h0;
            m_chan  = (g >= 0) ? g : 0;
            if (m && g >= 0) m_ptr = (g + 1) % 4;
        end
        @(posedge clk);
        #1;
        check("out_valid", {63'b0, out_valid}, {63'b0, m_valid});
        check("out_data", {52'b0, out_data}, {52'b0, m_data});
        check("out_chan", {62'b0, out_chan}, 64'(m_chan));
    endtask

    initial begin
        logic [47:0] rd;
        rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = 24'h332211;

        step(1, 1, 0, 4'hF, 1, 48'h444333222111);
        check("rst_ready_zero", {60'b0, in_ready}, 64'h0);
        step(1, 1, 0, 4'hF, 1, 48'h444333222111);
        step(0, 1, 0, 4'hF, 1, 48'h444333222111);
        check("first_after_rst", {62'b0, out_chan}, 64'h0);

        step(0, 0, 2, 4'b0100, 1, 48'h000ABC000000);
        check("fixed_data", {52'b0, out_data}, 64'hABC);
        check("fixed_chan", {62'b0, out_chan}, 64'h2);
        step(0, 0, 3, 4'b0100, 1, 48'h000ABC000000);
        check("fixed_invalid_drop", {63'b0, out_valid}, 64'h0);

        step(1, 1, 0, 4'hF, 1, 48'h0);
        for (int i = 0; i < 6; i++) begin
            rd = {$urandom, $urandom};
            step(0, 1, 0, 4'hF, 1, rd);
            check("rr_seq", {62'b0, out_chan}, 64'(i % 4));
        end

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 4'hF, 0, {$urandom, $urandom});
            check("stall_ready", {60'b0, in_ready}, 64'h0);
            check("stall_chan", {62'b0, out_chan}, 64'h1);
        end
        step(0, 1, 0, 4'hF, 1, {$urandom, $urandom});
        check("release_next", {62'b0, out_chan}, 64'h2);

        step(0, 0, 1, 4'hF, 1, {$urandom, $urandom});
        check("alt_fixed", {62'b0, out_chan}, 64'h1);
        step(0, 0, 1, 4'hF, 1, {$urandom, $urandom});
        step(0, 1, 1, 4'hF, 1, {$urandom, $urandom});
        check("alt_rr_resume", {62'b0, out_chan}, 64'h3);

        for (int i = 0; i < 2000; i++) begin
            rd = {$urandom, $urandom};
            step($urandom_range(0, 49) == 0, 1'($urandom), 2'($urandom), 4'($urandom),
                 $urandom_range(0, 9) < 7, rd);
        end

        @(posedge clk); #1;
        rst3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ch3_oor_ready", {61'b0, in_ready3}, 64'h0);
            @(posedge clk); #1;
            check("ch3_oor_valid", {63'b0, out_valid3}, 64'h0);
        end
        sel3 = 2'd2;
        #1;
        check("ch3_sel2_ready", {61'b0, in_ready3}, 64'h4);
        @(posedge clk); #1;
        check("ch3_sel2_chan", {62'b0, out_chan3}, 64'h2);
        check("ch3_sel2_data", {56'b0, out_data3}, 64'h33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
